// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states, keyboard command/response bytes
// and the odd-parity helper used on the host transmit path.
package ps2_pkg;

   typedef enum logic [3:0] {
      IDLE,
      INHIBIT,
      RTS,
      WAIT_FIRST,
      SHIFT,
      ACK,
      ACK_REL,
      DONE,
      ERR
   } tx_state_t;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ECHO     = 8'hEE;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] RSP_ACK      = 8'hFA;
   localparam logic [7:0] RSP_RESEND   = 8'hFE;

   localparam logic [1:0] RETRY_LIMIT  = 2'd2;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronisers for the PS/2 clock and data pins plus a falling-edge
// strobe on the synced clock; shared with the receive path.
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic key_clk,
   input  logic key_data,
   output logic clk_sync,
   output logic data_sync,
   output logic clk_fall
);

   logic [1:0] clk_ff;
   logic [1:0] data_ff;
   logic       clk_prev;

   // Idle PS/2 lines float high, so the chains reset to 1 to avoid a fake edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_ff   <= 2'b11;
         data_ff  <= 2'b11;
         clk_prev <= 1'b1;
      end else begin
         clk_ff   <= {clk_ff[0], key_clk};
         data_ff  <= {data_ff[0], key_data};
         clk_prev <= clk_ff[1];
      end
   end

   assign clk_sync  = clk_ff[1];
   assign data_sync = data_ff[1];
   assign clk_fall  = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter (inhibit, request-to-send, device-clocked).
// Define PS2_TX_RETRY_EN to retry a failed byte up to two more times.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES        = 5000,
   parameter int START_TIMEOUT_CYCLES  = 750000,
   parameter int PACKET_TIMEOUT_CYCLES = 100000
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       key_clk,
   input  logic       key_data,
   output logic       key_clk_oe,
   output logic       key_data_oe
);

   localparam int MAX_TO     = (START_TIMEOUT_CYCLES > PACKET_TIMEOUT_CYCLES) ?
                               START_TIMEOUT_CYCLES : PACKET_TIMEOUT_CYCLES;
   localparam int MAX_CYCLES = (MAX_TO > INHIBIT_CYCLES) ? MAX_TO : INHIBIT_CYCLES;
   localparam int TW         = $clog2(MAX_CYCLES) + 1;

   localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] START_LAST   = TW'(START_TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] PACKET_LAST  = TW'(PACKET_TIMEOUT_CYCLES - 1);

   tx_state_t     state_q, state_d;
   logic [TW-1:0] timer_q, timer_d, timer_inc;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_q, par_d;
   logic          data_oe_q, data_oe_d;
   logic          clk_sync, data_sync, clk_fall;
   logic          packet_to;
`ifdef PS2_TX_RETRY_EN
   logic [1:0]    retry_q, retry_d;
`endif

   ps2_line_sync u_sync (
      .clk       (clk_in),
      .rst       (rst_in),
      .key_clk   (key_clk),
      .key_data  (key_data),
      .clk_sync  (clk_sync),
      .data_sync (data_sync),
      .clk_fall  (clk_fall)
   );

   assign timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;
   assign packet_to = (timer_q >= PACKET_LAST);

   // Data-line drive is registered so the bit stays stable between device falls.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         bitcnt_q  <= '0;
         shreg_q   <= '0;
         par_q     <= 1'b0;
         data_oe_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         retry_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bitcnt_q  <= bitcnt_d;
         shreg_q   <= shreg_d;
         par_q     <= par_d;
         data_oe_q <= data_oe_d;
`ifdef PS2_TX_RETRY_EN
         retry_q   <= retry_d;
`endif
      end
   end

   // Timeouts are tested before the falling edge so a coincident fall still errors.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bitcnt_d  = bitcnt_q;
      shreg_d   = shreg_q;
      par_d     = par_q;
      data_oe_d = data_oe_q;
`ifdef PS2_TX_RETRY_EN
      retry_d   = retry_q;
`endif
      case (state_q)
         IDLE: begin
            data_oe_d = 1'b0;
            if (tx_valid) begin
               shreg_d  = tx_data;
               par_d    = odd_parity(tx_data);
               timer_d  = '0;
               bitcnt_d = '0;
`ifdef PS2_TX_RETRY_EN
               retry_d  = '0;
`endif
               state_d  = INHIBIT;
            end
         end
         INHIBIT: begin
            if (timer_q >= INHIBIT_LAST) begin
               data_oe_d = 1'b1;
               timer_d   = '0;
               state_d   = RTS;
            end else begin
               timer_d = timer_inc;
            end
         end
         RTS: begin
            timer_d = '0;
            state_d = WAIT_FIRST;
         end
         WAIT_FIRST: begin
            if (timer_q >= START_LAST) begin
               data_oe_d = 1'b0;
               state_d   = ERR;
            end else if (clk_fall) begin
               data_oe_d = ~shreg_q[0];
               bitcnt_d  = 4'd1;
               timer_d   = '0;
               state_d   = SHIFT;
            end else begin
               timer_d = timer_inc;
            end
         end
         SHIFT: begin
            if (packet_to) begin
               data_oe_d = 1'b0;
               state_d   = ERR;
            end else begin
               timer_d = timer_inc;
               if (clk_fall) begin
                  bitcnt_d = bitcnt_q + 4'd1;
                  if (bitcnt_q < 4'd8) begin
                     data_oe_d = ~shreg_q[bitcnt_q[2:0]];
                  end else if (bitcnt_q == 4'd8) begin
                     data_oe_d = ~par_q;
                  end else begin
                     data_oe_d = 1'b0;
                     state_d   = ACK;
                  end
               end
            end
         end
         ACK: begin
            if (packet_to) begin
               data_oe_d = 1'b0;
               state_d   = ERR;
            end else begin
               timer_d = timer_inc;
               if (clk_fall) begin
                  state_d = data_sync ? ERR : ACK_REL;
               end
            end
         end
         ACK_REL: begin
            if (packet_to) begin
               data_oe_d = 1'b0;
               state_d   = ERR;
            end else begin
               timer_d = timer_inc;
               if (clk_sync && data_sync) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         ERR: begin
            data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retry_q < RETRY_LIMIT) begin
               retry_d  = retry_q + 2'd1;
               timer_d  = '0;
               bitcnt_d = '0;
               state_d  = INHIBIT;
            end else begin
               state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
         end
         default: begin
            data_oe_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   assign tx_ready    = (state_q == IDLE);
   assign tx_busy     = (state_q != IDLE);
   assign tx_done     = (state_q == DONE);
`ifdef PS2_TX_RETRY_EN
   assign tx_err      = (state_q == ERR) && (retry_q == RETRY_LIMIT);
`else
   assign tx_err      = (state_q == ERR);
`endif
   assign key_clk_oe  = (state_q == INHIBIT) || (state_q == RTS);
   assign key_data_oe = data_oe_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 8'hED set-LEDs or 8'hFF reset, using the standard inhibit / request-to-send / device-clocked sequence.
- Sits beside the PS/2 receive path on the same key_clk/key_data pins. It drives the pins open-drain through output-enables.
- Raises tx_busy so the receive path ignores the line while a transmit is in progress.

Parameters:
- INHIBIT_CYCLES, 5000: clk_in cycles key_clk is held low before request-to-send (100 us at 50 MHz).
- START_TIMEOUT_CYCLES, 750000: maximum wait from clock release to the first device falling edge (15 ms).
- PACKET_TIMEOUT_CYCLES, 100000: maximum time from the first falling edge to ack completion (2 ms).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-high reset
- tx_data  in  8  byte to send; sampled on accept
- tx_valid  in  1  request; accepted when tx_valid & tx_ready
- tx_ready  out  1  high only in IDLE
- tx_busy  out  1  high in every state except IDLE
- tx_done  out  1  one-cycle pulse: byte sent and device acked
- tx_err  out  1  one-cycle pulse: timeout or missing ack
- key_clk  in  1  raw PS/2 clock pin level
- key_data  in  1  raw PS/2 data pin level
- key_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release
- key_data_oe  out  1  1 = pull PS/2 data low; 0 = release

Behaviour:
- Reset (async, active-high): state IDLE. tx_ready=1, tx_busy=0, tx_done=0, tx_err=0, key_clk_oe=0, key_data_oe=0, all counters 0. Both lines are released immediately, including when reset hits mid-transfer.
- Input sync: key_clk and key_data pass through 2-flop synchronisers, reset to 1. fall = prev & ~cur on the synced clock. A falling edge is seen 2–3 cycles after the pin edge.
- IDLE:
  - On tx_valid & tx_ready, latch tx_data into shreg.
  - Compute par = ~^tx_data (odd parity).
  - Go to INHIBIT. A tx_valid while not ready is ignored; there is no queue.
- INHIBIT:
  - key_clk_oe=1. Count INHIBIT_CYCLES.
  - At terminal count, set key_data_oe=1 (start bit) and go to RTS.
- RTS:
  - key_clk_oe=1, key_data_oe=1 for exactly 1 cycle.
  - Next cycle key_clk_oe=0 and go to WAIT_FIRST.
- WAIT_FIRST:
  - key_data_oe=1; timer counts up.
  - On fall, drive key_data_oe=~shreg[0], set bitcnt=1, clear timer, go to SHIFT.
  - Timer reaching START_TIMEOUT_CYCLES goes to ERR.
- SHIFT:
  - Each fall drives the next value on key_data_oe (1 means the bit value is 0), after which bitcnt increments:
    - falls 2..8: bits 1..7
    - fall 9: parity (key_data_oe=~par)
    - fall 10: release data (stop bit, key_data_oe=0)
  - The value is held until the next fall.
  - When bitcnt reaches 10, go to ACK.
- ACK:
  - On fall 11, sample synced data. 0 goes to ACK_REL; 1 goes to ERR (no ack).
- ACK_REL: wait until synced clock=1 and data=1, then go to DONE.
- PACKET timeout: the timer runs in SHIFT, ACK and ACK_REL. Reaching PACKET_TIMEOUT_CYCLES goes to ERR.
- DONE: tx_done=1 for one cycle, then IDLE.
- ERR: both oe=0, tx_err=1 for one cycle, then IDLE.
- Simultaneous events: a timeout terminal count in the same cycle as a fall takes priority and goes to ERR.
- tx_done and tx_err are never high together.
- Counters: the timer width is $clog2 of the maximum timeout parameter plus 1 and saturates. bitcnt is 4 bits.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - Any ERR cause restarts from INHIBIT with the latched byte, up to 2 retries, tracked by a 2-bit retry counter cleared on accept.
  - tx_err pulses only after the third failure. tx_busy stays high across retries.
- Undefined: the first failure pulses tx_err and returns to IDLE.

Decomposition:
- ps2_pkg holds:
  - state enum: IDLE, INHIBIT, RTS, WAIT_FIRST, SHIFT, ACK, ACK_REL, DONE, ERR
  - command constants: CMD_SET_LEDS 8'hED, CMD_ECHO 8'hEE, CMD_RESET 8'hFF
  - response constants: RSP_ACK 8'hFA, RSP_RESEND 8'hFE
- Sub-module ps2_line_sync: 2-flop synchroniser plus falling-edge detect for clock/data. It is reused by the receive path.

Test Plan (INHIBIT_CYCLES=20, START_TIMEOUT_CYCLES=200, PACKET_TIMEOUT_CYCLES=2000; device BFM clock period 40 cycles):
- Send 8'hED with BFM acking:
  - key_clk_oe high for 20 cycles, then data low.
  - BFM samples on rising edges: 0 (start), bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once; tx_ready returns to 1.
- Send 8'hF4: BFM decodes data 8'hF4, parity 0; tx_done pulses once.
- Device never clocks: tx_err pulses 200 cycles after clock release; both oe=0; tx_done stays 0.
- BFM leaves data high on fall 11: tx_err pulses; state is IDLE.
- Assert rst_in mid-SHIFT, after fall 5:
  - key_clk_oe=0, key_data_oe=0 in the same cycle.
  - tx_ready=1 after release; no pulses.
- tx_valid held high during a transfer with 8'h00 queued behind 8'hFF: only 8'hFF is transmitted until tx_ready rises. With PS2_TX_RETRY_EN and an always-silent device, exactly one tx_err occurs after 3 attempts.
